// File: rtl/fifo_fwft_adapter.sv
// First-word-fall-through adapter in front of a standard-mode FIFO whose read data arrives RD_LATENCY cycles
// after fifo_rd_en. A small circular output buffer presents the head word on m_data/m_valid.
module fifo_fwft_adapter #(
    parameter int WIDTH      = 9,
    parameter int RD_LATENCY = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] fifo_dout,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    output logic [WIDTH-1:0] m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [2:0]       level,
    output logic             ovf_err
);
    localparam int               DEPTH     = RD_LATENCY + 2;
    localparam int               PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [2:0]       DEPTH_CNT = 3'(DEPTH);

    logic [WIDTH-1:0]      buf_mem [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [2:0]            count_q, count_d;
    logic [RD_LATENCY-1:0] pipe_q, pipe_d;
    logic                  ovf_err_q, ovf_err_d;
    logic [2:0]            inflight;
    logic [3:0]            occupancy;
    logic                  capture;
    logic                  transfer;
    logic                  store;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            inflight = inflight + 3'(pipe_q[i]);
        end
    end

    // Reserve a slot for every outstanding read so a returning word always has room,
    // without looking at m_ready (keeps the read strobe off the consumer's timing path).
    assign occupancy  = {1'b0, count_q} + {1'b0, inflight};
    assign fifo_rd_en = !rst && !fifo_empty && (occupancy < {1'b0, DEPTH_CNT});

    assign m_valid = (count_q != 3'd0);
    assign m_data  = buf_mem[rd_ptr_q];
    assign level   = count_q;
    assign ovf_err = ovf_err_q;

    always_comb begin
        pipe_d    = '0;
        pipe_d[0] = fifo_rd_en;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    always_comb begin
        capture   = pipe_q[RD_LATENCY-1];
        transfer  = m_valid && m_ready;
        store     = capture && ((count_q != DEPTH_CNT) || transfer);
        rd_ptr_d  = transfer ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d  = store ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        count_d   = count_q;
        if (store && !transfer) begin
            count_d = count_q + 3'd1;
        end else if (!store && transfer) begin
            count_d = count_q - 3'd1;
        end
        ovf_err_d = ovf_err_q || (capture && !store);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q  <= '0;
            wr_ptr_q  <= '0;
            count_q   <= '0;
            pipe_q    <= '0;
            ovf_err_q <= 1'b0;
        end else begin
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            count_q   <= count_d;
            pipe_q    <= pipe_d;
            ovf_err_q <= ovf_err_d;
        end
    end

    // Storage is deliberately left out of reset; m_data is only meaningful while m_valid is high.
    always_ff @(posedge clk) begin
        if (store) begin
            buf_mem[wr_ptr_q] <= fifo_dout;
        end
    end
endmodule
